// File: rtl/moore_fsm_cfg.sv
// Table-driven Moore machine. The next-state and output tables are written at run time.
// The state advances one table lookup per cycle while ctrl_in is high.
module moore_fsm_cfg #(
   parameter int NUM_STATES  = 2,
   parameter int STATE_W     = 1,
   parameter int IN_W        = 2,
   parameter int OUT_W       = 1,
   parameter int CNT_W       = 8,
   parameter int RESET_STATE = 0
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic [IN_W-1:0]                              sw_in,
   input  logic                                         ctrl_in,
   input  logic                                         load_in,
   input  logic [STATE_W-1:0]                           state_in,
   input  logic                                         cfg_we,
   input  logic                                         cfg_sel,
   input  logic [STATE_W+IN_W-1:0]                      cfg_addr,
   input  logic [((STATE_W > OUT_W) ? STATE_W : OUT_W)-1:0] cfg_data,
   input  logic                                         err_clr,
   output logic [STATE_W-1:0]                           state,
   output logic [OUT_W-1:0]                             out,
   output logic [CNT_W-1:0]                             step_cnt,
   output logic                                         err
);

   localparam int                 ADDR_W     = STATE_W + IN_W;
   localparam int                 NEXT_DEPTH = 2 ** ADDR_W;
   localparam int                 OUT_DEPTH  = 2 ** STATE_W;
   localparam logic [STATE_W:0]   NUM_ST     = (STATE_W + 1)'(NUM_STATES);
   localparam logic [STATE_W-1:0] RST_ST     = STATE_W'(RESET_STATE);

   // One extra bit lets NUM_STATES == 2**STATE_W compare correctly.
   function automatic logic legal(input logic [STATE_W-1:0] s);
      return {1'b0, s} < NUM_ST;
   endfunction

   logic [STATE_W-1:0] next_tbl_q [NEXT_DEPTH];
   logic [OUT_W-1:0]   out_tbl_q  [OUT_DEPTH];

   logic [STATE_W-1:0] state_q, state_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [STATE_W-1:0] nxt;
   logic [STATE_W-1:0] cfg_st_next;
   logic [STATE_W-1:0] cfg_st_out;
   logic               cfg_next_ok;
   logic               cfg_out_ok;
   logic               cfg_err;

   // Lookups read the registered tables, so a write in the same cycle is not yet visible.
   assign nxt         = next_tbl_q[{state_q, sw_in}];
   assign cfg_st_next = cfg_addr[ADDR_W-1:IN_W];
   assign cfg_st_out  = cfg_addr[STATE_W-1:0];
   assign cfg_next_ok = legal(cfg_data[STATE_W-1:0]) && legal(cfg_st_next);
   assign cfg_out_ok  = (cfg_addr[ADDR_W-1:STATE_W] == '0) && legal(cfg_st_out);
   assign cfg_err     = cfg_we && (cfg_sel ? !cfg_out_ok : !cfg_next_ok);

   // NOTE: every signal gets a default before any branch so that no latch can be inferred.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (err_clr) err_d = 1'b0;
      if (load_in) begin
         if (legal(state_in)) begin
            state_d = state_in;
            out_d   = out_tbl_q[state_in];
            cnt_d   = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (ctrl_in) begin
         state_d = nxt;
         out_d   = out_tbl_q[nxt];
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      // A new error outranks err_clr in the same cycle.
      if (cfg_err) err_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RST_ST;
         out_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the tables need a defined reset image (self-loop, zero output), so they are built
   // from resettable flops rather than an inferred RAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NEXT_DEPTH; i++) next_tbl_q[i] <= STATE_W'(i >> IN_W);
         for (int i = 0; i < OUT_DEPTH; i++)  out_tbl_q[i]  <= '0;
      end else if (cfg_we) begin
         if (!cfg_sel && cfg_next_ok) next_tbl_q[cfg_addr] <= cfg_data[STATE_W-1:0];
         if (cfg_sel && cfg_out_ok)   out_tbl_q[cfg_st_out] <= cfg_data[OUT_W-1:0];
      end
   end

   assign state    = state_q;
   assign out      = out_q;
   assign step_cnt = cnt_q;
   assign err      = err_q;

endmodule
